// File: rtl/serial_pkg.sv
// Shared types for the serial byte loader: FSM state encoding and bit counter sizing.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_DATA_W = 16;
  // Counter must reach DATA_W+1 when a parity bit follows the data bits.
  localparam int CNT_W_MAX  = $clog2(MAX_DATA_W + 2);

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/serial_byte_loader_if.sv
// Serial input, word output handshake and status bundle of serial_byte_loader.
// Handshake: a word transfers on a rising edge where data_valid && data_ready.
interface serial_byte_loader_if #(parameter int DATA_W = 8);
  import serial_pkg::*;

  logic              sin_bit;
  logic              sin_valid;
  logic              sin_start;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              overrun;
  logic              parity_err;
  state_t            state;

  modport master (
    output sin_bit, sin_valid, sin_start, data_ready,
    input  data_out, data_valid, busy, overrun, parity_err, state
  );

  modport slave (
    input  sin_bit, sin_valid, sin_start, data_ready,
    output data_out, data_valid, busy, overrun, parity_err, state
  );

endinterface

// File: rtl/serial_byte_loader_shift_reg.sv
// Shift register and bit counter for serial_byte_loader.
// SERIAL_BYTE_LOADER_PARITY_EN: word excludes the trailing parity bit.
module sbl_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              capture,
  input  logic              clear,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic [CNT_W-1:0]  bit_cnt
);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] first;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr[DATA_W-2:0], bit_in};
      assign first   = {{(DATA_W-1){1'b0}}, bit_in};
    end else begin : g_lsb
      assign shifted = {bit_in, sr[DATA_W-1:1]};
      assign first   = {bit_in, {(DATA_W-1){1'b0}}};
    end
  endgenerate

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  // The final frame bit is parity, so the data bits already sit in sr.
  assign word = sr;
`else
  assign word = shifted;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (restart) begin
      sr      <= first;
      bit_cnt <= CNT_W'(1);
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (capture) begin
      sr      <= shifted;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_byte_loader.sv
// Bit-serial to word converter with a decoupled valid/ready output register.
// SERIAL_BYTE_LOADER_PARITY_EN adds a trailing even-parity bit per frame.
module serial_byte_loader
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  serial_byte_loader_if.slave bus
);

  localparam int CNT_W = cnt_width(DATA_W);
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] word;
  logic              last_bit;
  logic              restart;
  logic              capture;
  logic              word_ok;
  logic              out_free;

  always_comb begin
    last_bit = (state == SHIFT) && bus.sin_valid && (bit_cnt == CNT_W'(FRAME_LEN - 1));
    // A start flag on the final bit does not abort: completion takes priority.
    restart  = bus.sin_valid && bus.sin_start && !last_bit;
    capture  = (state == SHIFT) && bus.sin_valid && !restart;
    out_free = !bus.data_valid || bus.data_ready;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    word_ok  = ((^word) == bus.sin_bit);
`else
    word_ok  = 1'b1;
`endif
  end

  sbl_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CNT_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .capture(capture),
    .clear  (last_bit),
    .bit_in (bus.sin_bit),
    .word   (word),
    .bit_cnt(bit_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (restart)  state <= SHIFT;
        SHIFT:   if (last_bit) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (last_bit && word_ok && out_free) begin
        bus.data_out   <= word;
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end

      if (last_bit && word_ok && !out_free) bus.overrun <= 1'b1;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      bus.parity_err <= last_bit && !word_ok;
`endif
    end
  end

`ifndef SERIAL_BYTE_LOADER_PARITY_EN
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy  = (state == SHIFT);
  assign bus.state = state;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader with a frame-level reference model.
module tb_serial_byte_loader;
  import serial_pkg::*;

  localparam int DATA_W    = 8;
  localparam bit MSB_FIRST = 1'b1;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_byte_loader_if #(.DATA_W(DATA_W)) bus();

  serial_byte_loader #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  bit                frame_q[$];
  logic [DATA_W-1:0] m_data    = '0;
  logic              m_valid   = 1'b0;
  logic              m_overrun = 1'b0;
  logic              m_perr    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic [DATA_W-1:0] w;
    logic done;
    logic ok;
    logic free;
    if (rst) begin
      frame_q.delete();
      m_data = '0; m_valid = 1'b0; m_overrun = 1'b0; m_perr = 1'b0;
      return;
    end
    w = '0; done = 1'b0; ok = 1'b1;
    if (bus.sin_valid) begin
      if (bus.sin_start && frame_q.size() != FRAME_LEN - 1) begin
        frame_q.delete();
        frame_q.push_back(bus.sin_bit);
      end else if (frame_q.size() > 0) begin
        frame_q.push_back(bus.sin_bit);
      end
      if (frame_q.size() == FRAME_LEN) begin
        done = 1'b1;
        for (int k = 0; k < DATA_W; k++) w[MSB_FIRST ? DATA_W-1-k : k] = frame_q[k];
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
        ok = ((^w) == frame_q[DATA_W]);
`endif
        frame_q.delete();
      end
    end
    free   = !m_valid || bus.data_ready;
    m_perr = done && !ok;
    if (done && ok && free) begin
      m_data  = w;
      m_valid = 1'b1;
    end else if (m_valid && bus.data_ready) begin
      m_valid = 1'b0;
    end
    if (done && ok && !free) m_overrun = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  initial forever begin
    @(negedge clk);
    chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
    chk("data_out",   32'(bus.data_out),   32'(m_data));
    chk("busy",       32'(bus.busy),       32'(frame_q.size() > 0));
    chk("overrun",    32'(bus.overrun),    32'(m_overrun));
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    if (!rst && bus.data_valid && bus.data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected actual=%0h required=none t=%0t", bus.data_out, $time);
      end else begin
        chk("xfer_word", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input logic st, input int gap);
    bus.sin_valid = 1'b1;
    bus.sin_bit   = b;
    bus.sin_start = st;
    tick();
    bus.sin_valid = 1'b0;
    bus.sin_start = 1'b0;
    bus.sin_bit   = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic bit_at(input logic [DATA_W-1:0] w, input int k);
    if (k < DATA_W) return MSB_FIRST ? w[DATA_W-1-k] : w[k];
    return ^w;
  endfunction

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int k = 0; k < FRAME_LEN; k++) send_bit(bit_at(w, k), k == 0, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit t1_bits[8] = '{1, 1, 1, 0, 0, 1, 1, 0};
    int gaps[8]    = '{0, 1, 2, 3, 0, 1, 2, 0};
    logic [DATA_W-1:0] w;

    bus.sin_bit = 1'b0; bus.sin_valid = 1'b0; bus.sin_start = 1'b0; bus.data_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_valid",    32'(bus.data_valid), 32'h0);
    chk("rst_busy",     32'(bus.busy), 32'h0);
    chk("rst_overrun",  32'(bus.overrun), 32'h0);
    rst = 1'b0;
    tick();

    // 1: fixed bit pattern, consumer always ready
    bus.data_ready = 1'b1;
    exp_q.push_back(8'hE6);
    for (int k = 0; k < 8; k++) send_bit(t1_bits[k], k == 0, 0);
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    send_bit(1'b1, 1'b0, 0);
`endif
    chk("t1_data", 32'(bus.data_out), 32'hE6);
    chk("t1_valid", 32'(bus.data_valid), 32'h1);
    tick();
    chk("t1_valid_1clk", 32'(bus.data_valid), 32'h0);

    // 2: all ones with idle gaps between bits
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 8; k++) begin
      send_bit(1'b1, k == 0, gaps[k]);
      if (k == 0) chk("t2_busy_first", 32'(bus.busy), 32'h1);
    end
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    chk("t2_busy_before_par", 32'(bus.busy), 32'h1);
    send_bit(1'b0, 1'b0, 0);
`endif
    chk("t2_data", 32'(bus.data_out), 32'hFF);
    chk("t2_busy_done", 32'(bus.busy), 32'h0);
    tick();

    // 3: consumer stalled, second word dropped
    bus.data_ready = 1'b0;
    send_word(8'h0F);
    send_word(8'hF0);
    chk("t3_data_held", 32'(bus.data_out), 32'h0F);
    chk("t3_overrun", 32'(bus.overrun), 32'h1);
    chk("t3_valid", 32'(bus.data_valid), 32'h1);
    exp_q.push_back(8'h0F);
    bus.data_ready = 1'b1;
    tick();
    chk("t3_valid_fall", 32'(bus.data_valid), 32'h0);
    chk("t3_overrun_sticky", 32'(bus.overrun), 32'h1);

    // 4: resync by sin_start mid-frame
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    chk("t4_no_partial", 32'(bus.data_valid), 32'h0);
    exp_q.push_back(8'h00);
    send_word(8'h00);
    chk("t4_data", 32'(bus.data_out), 32'h00);
    chk("t4_valid", 32'(bus.data_valid), 32'h1);
    tick();

    // 5: async reset mid-frame and with a word pending
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("t5a_busy", 32'(bus.busy), 32'h0);
    chk("t5a_overrun", 32'(bus.overrun), 32'h0);
    tick();
    rst = 1'b0;
    bus.data_ready = 1'b0;
    send_word(8'h3C);
    chk("t5b_valid_pre", 32'(bus.data_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5b_valid", 32'(bus.data_valid), 32'h0);
    chk("t5b_data", 32'(bus.data_out), 32'h0);
    tick();
    rst = 1'b0;
    bus.data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    chk("t5_data", 32'(bus.data_out), 32'hA5);
    tick();

    // 7: load coincides with transfer; start flag on the final bit
    bus.data_ready = 1'b0;
    send_word(8'h3C);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h5A);
    w = 8'h5A;
    for (int k = 0; k < FRAME_LEN - 1; k++) send_bit(bit_at(w, k), k == 0, 0);
    bus.data_ready = 1'b1;
    send_bit(bit_at(w, FRAME_LEN - 1), 1'b1, 0);
    chk("t7_data", 32'(bus.data_out), 32'h5A);
    chk("t7_valid", 32'(bus.data_valid), 32'h1);
    chk("t7_overrun", 32'(bus.overrun), 32'h0);
    chk("t7_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t7_valid_fall", 32'(bus.data_valid), 32'h0);

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    // 6: E6 has five ones, so even parity bit is 1
    w = 8'hE6;
    for (int k = 0; k < DATA_W; k++) send_bit(bit_at(w, k), k == 0, 0);
    send_bit(1'b0, 1'b0, 0);
    chk("t6_perr", 32'(bus.parity_err), 32'h1);
    chk("t6_no_valid", 32'(bus.data_valid), 32'h0);
    tick();
    chk("t6_perr_pulse", 32'(bus.parity_err), 32'h0);
    exp_q.push_back(8'hE6);
    for (int k = 0; k < DATA_W; k++) send_bit(bit_at(w, k), k == 0, 0);
    send_bit(1'b1, 1'b0, 0);
    chk("t6_data", 32'(bus.data_out), 32'hE6);
    chk("t6_overrun", 32'(bus.overrun), 32'h0);
    tick();
`endif

    tick(); tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
